tt_um_hoene_frame_select: RTL and testbench
===========================================

Name: tt_um_hoene_frame_select

Overview:
- Parametrised next-generation frame selector for the daisy-chained LED serial stream.
- Sits between the Manchester decoder, which supplies bit strobes, and the Manchester encoder, which consumes the forwarded bits.
- Claims up to MAX_FRAMES consecutive unclaimed frames for the local LED/PWM logic, clears their claim bit on the forwarded stream, and checks per-frame parity.
- Latches the payload of each claimed frame and flags protocol errors; while in error, forwarding is gated.

Parameters:
- FRAME_BITS, 32, bits per frame: bit 0 is the claim flag, bits 1..FRAME_BITS-2 are the payload (PW=FRAME_BITS-2), the last bit is parity. Minimum 4.
- MAX_FRAMES, 2, maximum number of frames one node can claim. IW=$clog2(MAX_FRAMES+1).
- PARITY_ODD, 0, 0 = even parity over payload plus parity bit, 1 = odd parity.
- STRICT_TAIL, 0, 1 = a claim bit of 1 seen in DONE is an error.

Ports:
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- in_sync  in  1  decoder locked; low = stream not aligned
- in_valid  in  1  one-cycle strobe, one per received bit
- in_data  in  1  received bit, valid with in_valid
- frame_count  in  IW  frames to claim, 0..MAX_FRAMES; values above MAX_FRAMES are clamped to MAX_FRAMES; sampled at each frame start
- out_valid  out  1  forwarded bit strobe
- out_data  out  1  forwarded bit
- payload  out  PW  last accepted payload, MSB = first payload bit received
- load  out  1  one-cycle pulse: payload updated
- load_idx  out  IW  index (0-based) of the frame that caused load
- parity_err  out  1  one-cycle pulse on parity mismatch
- error  out  1  sticky protocol error
- state  out  2  0 WAIT, 1 RECV, 2 DONE, 3 ERROR

Behaviour:
- Reset: all outputs 0; state=WAIT; bit counter 0; frame index 0; payload shift register 0.
- Reset is asynchronous; a mid-frame reset discards the partial frame.
- Bit counter: increments on in_valid, wraps from FRAME_BITS-1 to 0. Frame start is bit counter 0.
- in_sync low:
  - counter, frame index and error clear; state=WAIT.
  - Transparent forwarding: out_valid<=in_valid, out_data<=in_data.
  - load and parity_err stay 0.
- Forwarding latency: exactly 1 clk. out_valid<=in_valid && !error; out_data<=in_data ^ flip, where flip=1 only on the claim bit of a frame being claimed.
- WAIT (frame index 0), at bit 0:
  - in_data=1 and frame_count!=0: claim the frame (flip), go to RECV.
  - Otherwise stay in WAIT and forward unchanged; the frame belongs upstream.
  - frame_count=0: pure pass-through, never claims.
- RECV:
  - Shift payload bits 1..FRAME_BITS-2 into the shift register and accumulate XOR parity.
  - At the last bit, compare the received parity bit against the expected value.
  - Parity OK: payload<=shift register; load=1 and load_idx=frame index, both in the cycle out_valid carries the parity bit. Frame index increments; if it reaches frame_count go to DONE, else stay in RECV for the next frame.
  - Parity mismatch: parity_err pulse; error<=1; state=ERROR; no load.
- RECV at bit 0 of frame index >0:
  - Claim bit must be 1; it is flipped.
  - Claim bit 0 means a gap in the sequence: error<=1, state=ERROR, and this bit is not forwarded.
- DONE: forward unchanged. If STRICT_TAIL=1 and bit 0 of a frame is 1: error, state=ERROR. If STRICT_TAIL=0, stay in DONE until in_sync drops.
- ERROR:
  - out_valid forced 0 from the cycle after detection.
  - No load, no flips.
  - Exit only via in_sync low or reset.
- Simultaneous events:
  - in_sync low takes priority over in_valid in the same cycle.
  - A frame_count change mid-frame takes effect at the next frame start.
- Parity accumulator and shift register clear at every frame start.

Test Plan:
- FRAME_BITS=8, MAX_FRAMES=2, frame_count=1, even parity. Send frame 1_101101_0 then 1_000001_1.
  - Out frame 1 = 0_101101_0; load=1, payload=6'b101101, load_idx=0; state=DONE.
  - Frame 2 forwarded unchanged.
- frame_count=2. Send frames 0_111111_0 (claimed upstream), 1_000011_0, 1_100000_1.
  - First frame forwarded unchanged, state stays WAIT.
  - Two loads: payloads 000011 (load_idx=0) then 100000 (load_idx=1); state=DONE.
- frame_count=2. Send 1_000011_0 then 0_000011_0.
  - First load occurs; second frame's bit 0 sets error=1, state=3.
  - out_valid stays 0 until in_sync drops, after which error=0 and state=0.
- Send 1_000001_0 (bad parity).
  - parity_err pulses once; error=1; no load; payload keeps its prior value.
- STRICT_TAIL=1, frame_count=1. Send valid frame then 1_000000_0 → error=1 at the second frame's bit 0.
- Reset asserted mid-frame at bit 3: all outputs 0 immediately (asynchronously). After release and in_sync, the next frame is claimed normally.

Source files
------------

// File: rtl/tt_um_hoene_frame_select.sv
// Frame selector for the daisy-chained LED serial stream.
// Claims up to MAX_FRAMES frames, clears their claim bit, checks parity.
module tt_um_hoene_frame_select #(
  parameter int FRAME_BITS  = 32,
  parameter int MAX_FRAMES  = 2,
  parameter int PARITY_ODD  = 0,
  parameter int STRICT_TAIL = 0,
  localparam int PW = FRAME_BITS - 2,
  localparam int IW = $clog2(MAX_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_sync,
  input  logic          in_valid,
  input  logic          in_data,
  input  logic [IW-1:0] frame_count,
  output logic          out_valid,
  output logic          out_data,
  output logic [PW-1:0] payload,
  output logic          load,
  output logic [IW-1:0] load_idx,
  output logic          parity_err,
  output logic          error,
  output logic [1:0]    state
);

  localparam int CW = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] fc_q;
  logic [PW-1:0] sr_q;
  logic          par_q;

  logic          start, last, par_ok;
  logic          in_pl;
  logic [IW-1:0] fc_clamp;
  logic [IW-1:0] idx_nx;
  logic          last_frame;
  logic          claim, gap, load_d, perr_d, tail_err;
  logic          err_set;

  assign start  = in_valid && (cnt_q == '0);
  assign last   = in_valid && (cnt_q == CW'(FRAME_BITS - 1));
  assign in_pl  = in_valid && (cnt_q != '0) && (cnt_q <= CW'(PW));
  assign par_ok = ((par_q ^ in_data) == 1'(PARITY_ODD));

  assign fc_clamp = (frame_count > IW'(MAX_FRAMES)) ?
                    IW'(MAX_FRAMES) : frame_count;

  assign idx_nx     = idx_q + 1'b1;
  assign last_frame = (idx_nx >= fc_q);
  assign err_set    = gap || perr_d || tail_err;
  assign state      = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_WAIT;
    else        state_q <= state_d;
  end

  // Per-bit event decode for the current state
  always_comb begin
    claim    = 1'b0;
    gap      = 1'b0;
    load_d   = 1'b0;
    perr_d   = 1'b0;
    tail_err = 1'b0;
    if (in_sync) begin
      unique case (state_q)
        S_WAIT: claim = start && in_data && (fc_clamp != '0);
        S_RECV: begin
          claim  = start && in_data;
          gap    = start && !in_data;
          load_d = last && par_ok;
          perr_d = last && !par_ok;
        end
        S_DONE: tail_err = (STRICT_TAIL != 0) && start && in_data;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!in_sync) begin
      state_d = S_WAIT;
    end else begin
      unique case (1'b1)
        err_set:               state_d = S_ERR;
        claim:                 state_d = S_RECV;
        load_d && last_frame:  state_d = S_DONE;
        default: ;
      endcase
    end
  end

  // Bit counter, frame index, payload capture and forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      fc_q       <= '0;
      sr_q       <= '0;
      par_q      <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 1'b0;
      payload    <= '0;
      load       <= 1'b0;
      load_idx   <= '0;
      parity_err <= 1'b0;
      error      <= 1'b0;
    end else if (!in_sync) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sr_q       <= '0;
      par_q      <= 1'b0;
      out_valid  <= in_valid;
      out_data   <= in_data;
      load       <= 1'b0;
      parity_err <= 1'b0;
      error      <= 1'b0;
    end else begin
      out_valid  <= in_valid && !error && !gap;
      out_data   <= in_data ^ claim;
      load       <= load_d;
      parity_err <= perr_d;
      if (in_valid) begin
        cnt_q <= last ? '0 : cnt_q + 1'b1;
      end
      if (start) begin
        fc_q  <= fc_clamp;
        sr_q  <= '0;
        par_q <= 1'b0;
      end else if (in_pl) begin
        sr_q  <= {sr_q[PW-2:0], in_data};
        par_q <= par_q ^ in_data;
      end
      if (load_d) begin
        payload  <= sr_q;
        load_idx <= idx_q;
        idx_q    <= idx_nx;
      end
      if (err_set) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_frame_select.sv
// Scoreboard bench for tt_um_hoene_frame_select.
// FRAME_BITS=8, MAX_FRAMES=2; second instance with STRICT_TAIL=1.
module tb_tt_um_hoene_frame_select;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_sync = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_data = 1'b0;
  logic [1:0] frame_count = '0;

  logic       out_valid, out_data, load, parity_err, error;
  logic [5:0] payload;
  logic [1:0] load_idx, state;

  logic       s_out_valid, s_out_data, s_load, s_parity_err, s_error;
  logic [5:0] s_payload;
  logic [1:0] s_load_idx, s_state;

  int checks = 0;
  int errors = 0;
  int perr_cnt = 0;
  int load_cnt = 0;

  logic       exp_out[$];
  logic [7:0] exp_ld[$];

  always #5 clk = ~clk;

  tt_um_hoene_frame_select #(
    .FRAME_BITS(8), .MAX_FRAMES(2),
    .PARITY_ODD(0), .STRICT_TAIL(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_sync(in_sync),
    .in_valid(in_valid), .in_data(in_data),
    .frame_count(frame_count),
    .out_valid(out_valid), .out_data(out_data),
    .payload(payload), .load(load), .load_idx(load_idx),
    .parity_err(parity_err), .error(error), .state(state)
  );

  tt_um_hoene_frame_select #(
    .FRAME_BITS(8), .MAX_FRAMES(2),
    .PARITY_ODD(0), .STRICT_TAIL(1)
  ) u_strict (
    .clk(clk), .rst_n(rst_n), .in_sync(in_sync),
    .in_valid(in_valid), .in_data(in_data),
    .frame_count(frame_count),
    .out_valid(s_out_valid), .out_data(s_out_data),
    .payload(s_payload), .load(s_load), .load_idx(s_load_idx),
    .parity_err(s_parity_err), .error(s_error), .state(s_state)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pop scoreboard entries as the DUT produces them
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_out.size() == 0) chk("out_valid_unexp", out_valid, 1'b0);
        else chk("out_data", out_data, exp_out.pop_front());
      end
      if (load) begin
        load_cnt++;
        if (exp_ld.size() == 0) chk("load_unexp", load, 1'b0);
        else chk("load_pl_idx", {load_idx, payload}, exp_ld.pop_front());
      end
      if (parity_err) perr_cnt++;
    end
  end

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 1'b0;
    @(posedge clk); #1;
  endtask

  // f[7] is the claim bit (first on the wire), f[0] the parity bit
  task automatic send_frame(input logic [7:0] f,
                            input bit claimed,
                            input bit fwd);
    for (int i = 0; i < 8; i++) begin
      if (fwd) exp_out.push_back(f[7-i] ^ (claimed && i == 0));
      send_bit(f[7-i]);
    end
  endtask

  task automatic resync();
    in_sync = 1'b0;
    @(posedge clk); #1;
    chk("resync_state", state, 2'd0);
    chk("resync_error", error, 1'b0);
    in_sync = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({tag, "_outq"}, exp_out.size(), 0);
    chk({tag, "_ldq"}, exp_ld.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 1'b0);
    chk("rst_payload", payload, 6'd0);
    chk("rst_load", load, 1'b0);
    chk("rst_load_idx", load_idx, 2'd0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_state", state, 2'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_sync = 1'b1;
    @(posedge clk); #1;

    // single claim, tail forwarded unchanged
    frame_count = 2'd1;
    exp_ld.push_back({2'd0, 6'b101101});
    send_frame(8'b1_101101_0, 1'b1, 1'b1);
    chk("t1_state_done", state, 2'd2);
    send_frame(8'b1_000001_1, 1'b0, 1'b1);
    chk("t1_state_still_done", state, 2'd2);
    drain("t1");
    resync();

    // upstream-claimed frame skipped, then two claims
    frame_count = 2'd2;
    send_frame(8'b0_111111_0, 1'b0, 1'b1);
    chk("t2_state_wait", state, 2'd0);
    exp_ld.push_back({2'd0, 6'b000011});
    exp_ld.push_back({2'd1, 6'b100000});
    send_frame(8'b1_000011_0, 1'b1, 1'b1);
    chk("t2_state_recv", state, 2'd1);
    send_frame(8'b1_100000_1, 1'b1, 1'b1);
    chk("t2_state_done", state, 2'd2);
    drain("t2");
    resync();

    // gap in the claimed sequence
    frame_count = 2'd2;
    exp_ld.push_back({2'd0, 6'b000011});
    send_frame(8'b1_000011_0, 1'b1, 1'b1);
    send_frame(8'b0_000011_0, 1'b0, 1'b0);
    chk("t3_error", error, 1'b1);
    chk("t3_state", state, 2'd3);
    drain("t3");
    resync();

    // parity mismatch
    perr_cnt = 0;
    load_cnt = 0;
    frame_count = 2'd1;
    send_frame(8'b1_000001_0, 1'b1, 1'b1);
    drain("t4");
    chk("t4_perr_pulses", perr_cnt, 1);
    chk("t4_no_load", load_cnt, 0);
    chk("t4_error", error, 1'b1);
    chk("t4_state", state, 2'd3);
    chk("t4_payload_kept", payload, 6'b000011);
    resync();

    // frame_count above MAX_FRAMES clamps to two claims
    frame_count = 2'd3;
    exp_ld.push_back({2'd0, 6'b110000});
    exp_ld.push_back({2'd1, 6'b000000});
    send_frame(8'b1_110000_0, 1'b1, 1'b1);
    send_frame(8'b1_000000_0, 1'b1, 1'b1);
    send_frame(8'b1_111000_1, 1'b0, 1'b1);
    chk("t5_state_done", state, 2'd2);
    drain("t5");
    resync();

    // frame_count zero is pure pass-through
    frame_count = 2'd0;
    send_frame(8'b1_101101_0, 1'b0, 1'b1);
    chk("t6_state_wait", state, 2'd0);
    drain("t6");
    resync();

    // strict tail on the second instance
    frame_count = 2'd1;
    exp_ld.push_back({2'd0, 6'b101101});
    send_frame(8'b1_101101_0, 1'b1, 1'b1);
    chk("t7_strict_err_before", s_error, 1'b0);
    exp_out.push_back(1'b1);
    send_bit(1'b1);
    chk("t7_strict_err_bit0", s_error, 1'b1);
    chk("t7_strict_state", s_state, 2'd3);
    chk("t7_main_err", error, 1'b0);
    for (int i = 1; i < 8; i++) begin
      exp_out.push_back(1'b0);
      send_bit(1'b0);
    end
    chk("t7_main_state", state, 2'd2);
    drain("t7");
    resync();

    // asynchronous reset in the middle of a frame
    frame_count = 2'd1;
    exp_out.push_back(1'b0);
    send_bit(1'b1);
    exp_out.push_back(1'b1);
    send_bit(1'b1);
    exp_out.push_back(1'b0);
    send_bit(1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t8_rst_payload", payload, 6'd0);
    chk("t8_rst_state", state, 2'd0);
    chk("t8_rst_error", error, 1'b0);
    chk("t8_rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_ld.push_back({2'd0, 6'b000011});
    send_frame(8'b1_000011_0, 1'b1, 1'b1);
    chk("t8_state_done", state, 2'd2);
    chk("t8_payload", payload, 6'b000011);
    drain("t8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
